distance_motor_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational distance → Gray → motor/excess-3/7-segment path. Quantises a sampled sensor distance into a level (0..6), debounces it over consecutive samples, and drives a motor through a minimum-on-time state machine. Publishes the accepted level as Gray code, excess-3 and 7-segment outputs for the FPGA LEDs and display.

---
 rtl/distance_motor_ctrl_if.sv | 25 ++
 rtl/distance_motor_ctrl.sv | 143 ++++++++++++++
 tb/tb_distance_motor_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/distance_motor_ctrl_if.sv
// Sensor/motor bundle between the distance source and distance_motor_ctrl.
// Inputs come from the master side; the controller drives the level and motor results.
interface distance_motor_ctrl_if #(
    parameter int unsigned DIST_W = 5
);
    logic              sample_valid;
    logic [DIST_W-1:0] distance;
    logic              enable;
    logic              level_valid;
    logic [2:0]        level;
    logic [2:0]        gray_code;
    logic [3:0]        excess;
    logic [6:0]        seg;
    logic              motor_on;

    modport master (
        output sample_valid, distance, enable,
        input  level_valid, level, gray_code, excess, seg, motor_on
    );

    modport slave (
        input  sample_valid, distance, enable,
        output level_valid, level, gray_code, excess, seg, motor_on
    );
endinterface

// File: rtl/distance_motor_ctrl.sv
// Distance quantiser with debounce, minimum-on-time motor FSM and Gray/excess-3/7-seg display.
// Define HYSTERESIS_EN to switch the RUN->OFF threshold from ON_LEVEL+1 to OFF_LEVEL.
module distance_motor_ctrl #(
    parameter int unsigned DIST_W     = 5,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned STABLE_N   = 3,
    parameter int unsigned ON_LEVEL   = 2,
    parameter int unsigned OFF_LEVEL  = 4,
    parameter int unsigned MIN_ON_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    distance_motor_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STABLE_N + 1);
    localparam int unsigned TMR_W = (MIN_ON_CYC > 1) ? $clog2(MIN_ON_CYC) : 1;
`ifdef HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif
    // Without hysteresis the motor stops as soon as the level leaves the on band.
    localparam int unsigned OFF_TH = HYST ? OFF_LEVEL : ON_LEVEL + 1;

    localparam logic [2:0]       MAX_LV   = 3'd6;
    localparam logic [2:0]       ON_LV    = 3'(ON_LEVEL);
    localparam logic [2:0]       OFF_LV   = 3'(OFF_TH);
    localparam logic [CNT_W-1:0] RUN_FULL = CNT_W'(STABLE_N);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MIN_ON_CYC - 1);

    typedef enum logic [1:0] {ST_OFF, ST_HOLD, ST_RUN} state_e;

    logic [DIST_W-1:0] shifted;
    logic [2:0]        q;
    logic [2:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        level_q, level_d;
    logic              level_valid_q, level_valid_d;
    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [3:0]        excess_c;

    // Quantise the raw distance, clamped to the top level.
    always_comb begin
        shifted = bus.distance >> SHIFT;
        q       = (shifted > DIST_W'(MAX_LV)) ? MAX_LV : 3'(shifted);
    end

    // Debounce: accept a level once the updated run length reaches STABLE_N.
    always_comb begin
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        level_d       = level_q;
        level_valid_d = level_valid_q;
        if (bus.sample_valid) begin
            if (q == cand_q) begin
                if (cnt_q != RUN_FULL) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_d = q;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == RUN_FULL) begin
                level_d       = cand_d;
                level_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q        <= 3'd0;
            cnt_q         <= '0;
            level_q       <= 3'd0;
            level_valid_q <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
        end
    end

    // Motor FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state; losing enable overrides everything, including an unfinished HOLD.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_OFF: begin
                if (bus.enable && level_valid_q && (level_q <= ON_LV)) begin
                    state_d = ST_HOLD;
                    timer_d = TMR_LOAD;
                end
            end
            ST_HOLD: begin
                if (timer_q == '0) state_d = ST_RUN;
                else               timer_d = timer_q - TMR_W'(1);
            end
            ST_RUN: begin
                if (level_q >= OFF_LV) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
        if (!bus.enable) state_d = ST_OFF;
    end

    // Outputs: motor drive from state, display codes from the accepted level.
    always_comb begin
        bus.motor_on    = (state_q != ST_OFF);
        bus.level_valid = level_valid_q;
        bus.level       = level_q;
        bus.gray_code   = 3'd0;
        bus.excess      = 4'd0;
        bus.seg         = 7'b0000000;
        excess_c        = {1'b0, level_q} + 4'd3;
        if (level_valid_q) begin
            bus.gray_code = level_q ^ (level_q >> 1);
            bus.excess    = excess_c;
            case (excess_c)
                4'd3:    bus.seg = 7'b1001111;
                4'd4:    bus.seg = 7'b1100110;
                4'd5:    bus.seg = 7'b1101101;
                4'd6:    bus.seg = 7'b1111101;
                4'd7:    bus.seg = 7'b0000111;
                4'd8:    bus.seg = 7'b1111111;
                4'd9:    bus.seg = 7'b1101111;
                default: bus.seg = 7'b0000000;
            endcase
        end
    end

endmodule

// File: tb/tb_distance_motor_ctrl.sv
// Directed bench for distance_motor_ctrl: debounce, display decode, HOLD timing, enable and reset.
// Expectations follow HYSTERESIS_EN when the bench is built with it.
module tb_distance_motor_ctrl;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    distance_motor_ctrl_if #(.DIST_W(5)) bus ();

    distance_motor_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [4:0] d);
        bus.sample_valid = 1'b1;
        bus.distance     = d;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] lv,
                             input logic [2:0] g, input logic [3:0] ex,
                             input logic [6:0] sg, input logic m);
        chk({tag, ".valid"}, 32'(bus.level_valid), 32'(v));
        chk({tag, ".level"}, 32'(bus.level),       32'(lv));
        chk({tag, ".gray"},  32'(bus.gray_code),   32'(g));
        chk({tag, ".excess"},32'(bus.excess),      32'(ex));
        chk({tag, ".seg"},   32'(bus.seg),         32'(sg));
        chk({tag, ".motor"}, 32'(bus.motor_on),    32'(m));
    endtask

    initial begin
        int   seq_b [5];
        logic exp_m;
        n_assert = 0;
        n_fail   = 0;
        seq_b    = '{9, 9, 20, 9, 9};

        rst_n            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.distance     = 5'd0;
        bus.enable       = 1'b1;
        tick();
        tick();
        check_out("reset", 1'b0, 3'd0, 3'd0, 4'd0, 7'd0, 1'b0);
        rst_n = 1'b1;

        // Level 2 accepted on the third sample, motor follows one cycle later.
        sample(5'd9);
        chk("a.s1.valid", 32'(bus.level_valid), 32'd0);
        sample(5'd9);
        chk("a.s2.valid", 32'(bus.level_valid), 32'd0);
        sample(5'd9);
        check_out("a.acc2", 1'b1, 3'd2, 3'b011, 4'b0101, 7'b1101101, 1'b0);
        tick();
        chk("a.motor_on", 32'(bus.motor_on), 32'd1);

        // Level 6 (clamped from 7) during HOLD: motor held for the full HOLD, then one RUN cycle.
        sample(5'd28);
        sample(5'd28);
        sample(5'd28);
        check_out("c.acc6", 1'b1, 3'd6, 3'b101, 4'd9, 7'b1101111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("c.hold_motor", 32'(bus.motor_on), 32'd1);
        end
        tick();
        chk("c.drop_motor", 32'(bus.motor_on), 32'd0);

        // Interrupted run: 9,9,20,9,9 must not accept.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_out("b.reset", 1'b0, 3'd0, 3'd0, 4'd0, 7'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sample(5'(seq_b[i]));
            chk("b.no_accept", 32'(bus.level_valid), 32'd0);
        end
        sample(5'd9);
        check_out("b.acc2", 1'b1, 3'd2, 3'b011, 4'b0101, 7'b1101101, 1'b0);

        // Enable drop during HOLD, then re-arm.
        tick();
        chk("f.hold0", 32'(bus.motor_on), 32'd1);
        tick();
        chk("f.hold1", 32'(bus.motor_on), 32'd1);
        bus.enable = 1'b0;
        tick();
        chk("f.en_drop", 32'(bus.motor_on), 32'd0);
        tick();
        chk("f.en_low", 32'(bus.motor_on), 32'd0);
        bus.enable = 1'b1;
        tick();
        chk("f.rearm", 32'(bus.motor_on), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("f.hold_motor", 32'(bus.motor_on), 32'd1);
        end
        tick();
        chk("f.run_motor", 32'(bus.motor_on), 32'd1);

        // Level 3 in RUN: off without hysteresis, on with it; level 4 stops it in both.
        sample(5'd12);
        sample(5'd12);
        sample(5'd12);
        check_out("d.acc3", 1'b1, 3'd3, 3'b010, 4'd6, 7'b1111101, 1'b1);
        tick();
`ifdef HYSTERESIS_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;
`endif
        chk("d.lvl3_motor", 32'(bus.motor_on), 32'(exp_m));
        sample(5'd16);
        sample(5'd16);
        sample(5'd16);
        check_out("d.acc4", 1'b1, 3'd4, 3'b110, 4'd7, 7'b0000111, exp_m);
        tick();
        chk("d.lvl4_motor", 32'(bus.motor_on), 32'd0);

        // Reset while in RUN at level 1; a sample on the reset cycle is discarded.
        sample(5'd5);
        sample(5'd5);
        sample(5'd5);
        check_out("e.acc1", 1'b1, 3'd1, 3'b001, 4'd4, 7'b1100110, 1'b0);
        tick();
        chk("e.hold_motor", 32'(bus.motor_on), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("e.run_motor", 32'(bus.motor_on), 32'd1);
        rst_n            = 1'b0;
        bus.sample_valid = 1'b1;
        bus.distance     = 5'd5;
        tick();
        bus.sample_valid = 1'b0;
        check_out("e.reset", 1'b0, 3'd0, 3'd0, 4'd0, 7'd0, 1'b0);
        rst_n = 1'b1;
        sample(5'd5);
        sample(5'd5);
        chk("e.two_fresh", 32'(bus.level_valid), 32'd0);
        sample(5'd5);
        check_out("e.reacc1", 1'b1, 3'd1, 3'b001, 4'd4, 7'b1100110, 1'b0);
        tick();
        chk("e.motor_again", 32'(bus.motor_on), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
